// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/I-O responder: bus width, I/O addresses
// and the region decode of address bits [17:16].
package mem_io_responder_pkg;

  localparam int BUS_W = 8;

  localparam int DEC_HI = 17;
  localparam int DEC_LO = 16;
  localparam logic [1:0] DEC_IO = 2'b11;

  localparam logic [17:0] IO_UART = 18'h30000;
  localparam logic [17:0] IO_CLK  = 18'h30004;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_IO   = 2'd1,
    REGION_NONE = 2'd2
  } region_t;

  function automatic region_t decode(input logic [17:0] addr);
    if (addr[DEC_HI:DEC_LO] == DEC_IO) return REGION_IO;
    else if (!addr[DEC_HI])            return REGION_RAM;
    else                               return REGION_NONE;
  endfunction

endpackage

// File: rtl/mem_io_responder_sync_fifo.sv
// Circular synchronous FIFO with occupancy and next-cycle occupancy outputs.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module mem_io_responder_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_next
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // Head reads as zero when empty so the consumer never sees stale storage.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_comb begin
    count_next = count + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: 128 KB RAM plus the UART,
// cycle-counter and program-stop I/O window.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic [31:0]      mem_a,
  input  logic [BUS_W-1:0] mem_dout,
  input  logic             mem_wr,
  output logic [BUS_W-1:0] mem_din,
  output logic             io_buffer_full,
  input  logic             rx_valid,
  input  logic [BUS_W-1:0] rx_data,
  output logic             rx_ready,
  output logic             tx_valid,
  output logic [BUS_W-1:0] tx_data,
  input  logic             tx_ready,
  output logic             tx_overflow,
  output logic             prog_stop
);

  localparam int CNT_W = $clog2(TX_DEPTH) + 1;

  // Handshakes: a byte moves on a clock edge exactly when valid and ready are
  // both high with rdy_in high; valid never waits on ready, and rx_ready is a
  // combinational acknowledge of the RX byte presented in the same cycle.

  logic [17:0]      addr;
  logic             unused_addr_bits;
  region_t          region;
  logic             rd_cyc;
  logic             wr_cyc;

  logic [BUS_W-1:0] ram [2**RAM_AW];
  logic [BUS_W-1:0] ram_q;
  logic             ram_sel_q;
  logic [BUS_W-1:0] io_q;
  logic [BUS_W-1:0] io_rdata;

  logic [31:0]      counter;
  logic [31:0]      snapshot;
  logic             stop_pending;

  logic             uart_wr;
  logic             stop_wr;
  logic             tx_push;
  logic             tx_pop;
  logic [BUS_W:0]   tx_wdata;
  logic [BUS_W:0]   tx_head;
  logic             tx_empty;
  logic             tx_full;
  logic [CNT_W-1:0] tx_count;
  logic [CNT_W-1:0] tx_count_next;

  assign addr             = mem_a[17:0];
  assign unused_addr_bits = ^mem_a[31:18];
  assign region           = decode(addr);
  assign rd_cyc           = rdy_in && !mem_wr;
  assign wr_cyc           = rdy_in && mem_wr;

  assign rx_ready = rst_in && rd_cyc && (addr == IO_UART) && rx_valid;

  // Once the stop byte is queued the TX side is closed for good.
  assign uart_wr  = wr_cyc && (addr == IO_UART) && (mem_dout != '0) && !stop_pending;
  assign stop_wr  = wr_cyc && (addr == IO_CLK) && !stop_pending;
  assign tx_push  = uart_wr || stop_wr;
  assign tx_wdata = stop_wr ? {1'b1, {BUS_W{1'b0}}} : {1'b0, mem_dout};
  assign tx_pop   = rdy_in && tx_valid && tx_ready;
  assign tx_full  = (tx_count == CNT_W'(TX_DEPTH));

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_head[BUS_W-1:0];

  assign mem_din  = ram_sel_q ? ram_q : io_q;

  always_comb begin
    io_rdata = '0;
    if (!mem_wr && region == REGION_IO) begin
      case (addr)
        IO_UART:         io_rdata = rx_valid ? rx_data : '0;
        IO_CLK:          io_rdata = counter[7:0];
        IO_CLK + 18'd1:  io_rdata = snapshot[15:8];
        IO_CLK + 18'd2:  io_rdata = snapshot[23:16];
        IO_CLK + 18'd3:  io_rdata = snapshot[31:24];
        default:         io_rdata = '0;
      endcase
    end
  end

  // RAM has no reset; the registered select keeps mem_din at zero after reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (mem_wr && region == REGION_RAM) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
      ram_q <= ram[mem_a[RAM_AW-1:0]];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ram_sel_q      <= 1'b0;
      io_q           <= '0;
      counter        <= '0;
      snapshot       <= '0;
      stop_pending   <= 1'b0;
      tx_overflow    <= 1'b0;
      prog_stop      <= 1'b0;
      io_buffer_full <= 1'b0;
    end else if (rdy_in) begin
      counter        <= counter + 32'd1;
      ram_sel_q      <= !mem_wr && (region == REGION_RAM);
      io_q           <= io_rdata;
      io_buffer_full <= (tx_count_next >= CNT_W'(TX_DEPTH - FULL_MARGIN));
      if (rd_cyc && addr == IO_CLK)      snapshot     <= counter;
      if (stop_wr)                       stop_pending <= 1'b1;
      if (tx_push && tx_full && !tx_pop) tx_overflow  <= 1'b1;
      if (tx_pop && tx_head[BUS_W])      prog_stop    <= 1'b1;
    end
  end

  mem_io_responder_sync_fifo #(
    .WIDTH (BUS_W + 1),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk        (clk_in),
    .rst_n      (rst_in),
    .push       (tx_push),
    .wdata      (tx_wdata),
    .pop        (tx_pop),
    .rdata      (tx_head),
    .empty      (tx_empty),
    .count      (tx_count),
    .count_next (tx_count_next)
  );

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed-plus-random bench for mem_io_responder with a queue/array based
// reference model of RAM, TX stream, counter and sticky flags.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_overflow;
  logic        prog_stop;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .tx_overflow    (tx_overflow),
    .prog_stop      (prog_stop)
  );

  // clock / watchdog
  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model state
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  ram_m[int];
  logic        m_stop = 1'b0;
  logic        m_ovf  = 1'b0;
  logic        m_prog_stop = 1'b0;
  int unsigned m_cnt  = 0;
  int unsigned pre_cnt = 0;
  int          n_pops = 0;
  int          stop_pop_idx = 0;
  logic [8:0]  head_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: a pop will happen on the next rising edge
  always @(negedge clk_in) begin
    if (rst_in && rdy_in && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("tx_pop_unexpected", 32'(tx_valid), 32'd0);
      end else begin
        head_e = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(head_e[7:0]));
        n_pops++;
        if (head_e[8]) begin
          m_prog_stop  = 1'b1;
          stop_pop_idx = n_pops;
        end
      end
    end
  end

  // drivers
  task automatic tick();
    pre_cnt = m_cnt;
    @(posedge clk_in);
    if (rdy_in && rst_in) m_cnt++;
    #1;
  endtask

  task automatic model_push(input logic [8:0] v);
    if (exp_q.size() < 8) exp_q.push_back(v);
    else m_ovf = 1'b1;
  endtask

  task automatic rd(input logic [31:0] a);
    mem_a  = a;
    mem_wr = 1'b0;
    tick();
    mem_a  = 32'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a    = a;
    mem_dout = d;
    mem_wr   = 1'b1;
    tick();
    if (rdy_in) begin
      if (a[17] == 1'b0) ram_m[int'(a[16:0])] = d;
      else if (a[17:0] == 18'h30000 && d != 8'h00 && !m_stop) model_push({1'b0, d});
      else if (a[17:0] == 18'h30004 && !m_stop) begin
        model_push(9'h100);
        m_stop = 1'b1;
      end
    end
    mem_wr   = 1'b0;
    mem_a    = 32'd0;
    mem_dout = 8'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || tx_valid) && k < 60) begin
      tick();
      k++;
    end
    check({tag, "_model_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_tx_valid_low"}, 32'(tx_valid), 32'd0);
  endtask

  // stimulus
  int unsigned ra[16];
  logic [31:0] r;
  logic [16:0] a17;
  logic [7:0]  d8;
  int          base;
  int unsigned snap;

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; mem_a = 32'h30000; mem_wr = 1'b0; mem_dout = 8'd0;
    rx_valid = 1'b1; rx_data = 8'h5A; tx_ready = 1'b0;
    #12;
    check("rst_mem_din",        32'(mem_din), 32'd0);
    check("rst_rx_ready",       32'(rx_ready), 32'd0);
    check("rst_tx_valid",       32'(tx_valid), 32'd0);
    check("rst_tx_data",        32'(tx_data), 32'd0);
    check("rst_io_buffer_full", 32'(io_buffer_full), 32'd0);
    check("rst_tx_overflow",    32'(tx_overflow), 32'd0);
    check("rst_prog_stop",      32'(prog_stop), 32'd0);
    mem_a = 32'd0; rx_valid = 1'b0; rx_data = 8'd0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    m_cnt  = 0;

    // RAM basics and unmapped region
    wr(32'h00123, 8'hA5);
    check("ram_wr_din_zero", 32'(mem_din), 32'd0);
    rd(32'h00123);
    check("ram_rd_latency1", 32'(mem_din), 32'hA5);
    rd(32'h20010);
    check("unmapped_rd", 32'(mem_din), 32'd0);
    wr(32'h20010, 8'h99);
    rd(32'h20010);
    check("unmapped_wr_ignored", 32'(mem_din), 32'd0);

    // random RAM traffic; upper address bits are junk and must be ignored
    for (int i = 0; i < 16; i++) begin
      r     = $urandom();
      a17   = 17'($urandom_range(1, 131071));
      ra[i] = 32'(a17);
      d8    = 8'($urandom());
      wr({r[31:18], 1'b0, a17}, d8);
    end
    for (int i = 0; i < 16; i++) begin
      r = $urandom();
      rd({r[31:18], 1'b0, 17'(ra[i])});
      check($sformatf("ram_rand_%0d", i), 32'(mem_din), 32'(ram_m[int'(ra[i])]));
    end

    // TX stream, zero byte filtered
    tx_ready = 1'b1;
    base = n_pops;
    wr(32'h30000, 8'h41);
    wr(32'h30000, 8'h00);
    wr(32'h30000, 8'h42);
    drain("tx_basic");
    check("tx_basic_count", 32'(n_pops - base), 32'd2);
    check("tx_basic_no_ovf", 32'(tx_overflow), 32'd0);

    // fill, near-full and overflow
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      wr(32'h30000, 8'($urandom_range(1, 255)));
      check($sformatf("fill_full_%0d", i), 32'(io_buffer_full), 32'(exp_q.size() >= 6));
      check($sformatf("fill_ovf_%0d", i),  32'(tx_overflow), 32'(m_ovf));
    end
    check("fill_ovf_set", 32'(tx_overflow), 32'd1);
    tx_ready = 1'b1;
    base = n_pops;
    drain("fill");
    check("fill_drain_count", 32'(n_pops - base), 32'd8);
    check("fill_full_cleared", 32'(io_buffer_full), 32'd0);

    // cycle counter and snapshot
    idle($urandom_range(100, 130));
    rd(32'h30004);
    snap = pre_cnt;
    check("clk_b0", 32'(mem_din), 32'(snap[7:0]));
    rd(32'h30005);
    check("clk_b1", 32'(mem_din), 32'(snap[15:8]));
    rd(32'h30006);
    check("clk_b2", 32'(mem_din), 32'(snap[23:16]));
    rd(32'h30007);
    check("clk_b3", 32'(mem_din), 32'(snap[31:24]));

    // freeze with rdy_in low
    rd(32'h00123);
    rdy_in = 1'b0; mem_a = 32'h30000; mem_wr = 1'b1; mem_dout = 8'h77;
    rx_valid = 1'b1; rx_data = 8'h5A;
    #1;
    check("frozen_rx_ready", 32'(rx_ready), 32'd0);
    mem_wr = 1'b0;
    #1;
    check("frozen_rx_ready_rd", 32'(rx_ready), 32'd0);
    idle(10);
    check("frozen_mem_din", 32'(mem_din), 32'(ram_m[32'h123]));
    check("frozen_no_push", 32'(tx_valid), 32'd0);
    rdy_in = 1'b1; rx_valid = 1'b0; mem_a = 32'd0;
    rd(32'h30004);
    check("frozen_counter_b0", 32'(mem_din), 32'(pre_cnt[7:0]));
    rd(32'h30005);
    check("frozen_counter_b1", 32'(mem_din), 32'(pre_cnt[15:8]));

    // UART RX
    rx_valid = 1'b1; rx_data = 8'h37; mem_a = 32'h30000; mem_wr = 1'b0;
    #1;
    check("rx_ready_pulse", 32'(rx_ready), 32'd1);
    tick();
    mem_a = 32'd0; rx_valid = 1'b0;
    check("rx_data_read", 32'(mem_din), 32'h37);
    #1;
    check("rx_ready_drop", 32'(rx_ready), 32'd0);
    rd(32'h30000);
    check("rx_empty_read", 32'(mem_din), 32'd0);

    // program stop
    tx_ready = 1'b0;
    base = n_pops;
    wr(32'h30000, 8'h11);
    wr(32'h30000, 8'h22);
    wr(32'h30004, 8'h00);
    wr(32'h30000, 8'h55);
    check("stop_not_yet", 32'(prog_stop), 32'd0);
    tx_ready = 1'b1;
    drain("stop");
    check("stop_pop_count", 32'(n_pops - base), 32'd3);
    check("stop_third", 32'(stop_pop_idx - base), 32'd3);
    check("stop_set", 32'(prog_stop), 32'd1);
    check("ovf_sticky", 32'(tx_overflow), 32'd1);

    // asynchronous reset mid-cycle
    #3;
    rst_in = 1'b0;
    #1;
    check("areset_prog_stop", 32'(prog_stop), 32'd0);
    check("areset_ovf",       32'(tx_overflow), 32'd0);
    check("areset_mem_din",   32'(mem_din), 32'd0);
    check("areset_tx_valid",  32'(tx_valid), 32'd0);
    exp_q.delete();
    m_stop = 1'b0; m_ovf = 1'b0; m_prog_stop = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    m_cnt  = 0;
    rd(32'h30004);
    check("post_rst_counter", 32'(mem_din), 32'(pre_cnt[7:0]));
    base = n_pops;
    wr(32'h30000, 8'h66);
    drain("post_rst");
    check("post_rst_tx", 32'(n_pops - base), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
